// File: rtl/riscv_mem_responder_pkg.sv
// Shared definitions for the RISC-V memory responder: write size codes,
// the NOP instruction presented while loading, and the loader FSM encoding.
package riscv_mem_pkg;

  localparam logic [1:0]  SZ_NONE  = 2'd0;
  localparam logic [1:0]  SZ_BYTE  = 2'd1;
  localparam logic [1:0]  SZ_HALF  = 2'd2;
  localparam logic [1:0]  SZ_WORD  = 2'd3;

  localparam logic [31:0] NOP_INSN = 32'h00000013;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Byte-lane enables for a DM write of the given size code.
  function automatic logic [3:0] size_mask(input logic [1:0] sz);
    logic [3:0] m;
    case (sz)
      SZ_NONE: m = 4'b0000;
      SZ_BYTE: m = 4'b0001;
      SZ_HALF: m = 4'b0011;
      SZ_WORD: m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/riscv_mem_responder_if.sv
// Bus bundle between the core/host side and the memory responder.
// The master side is the core plus host loader; the slave side is the responder.
interface riscv_mem_responder_if #(parameter int AW = 16);

  logic [AW-1:0] pmar;
  logic [31:0]   pmdr;
  logic          dmr;
  logic [AW-1:0] dmar;
  logic [31:0]   dmdr;
  logic [1:0]    dmw;
  logic [AW-1:0] dmaw;
  logic [31:0]   dmdw;
  logic          ld_valid;
  logic [7:0]    ld_data;
  logic          ld_last;
  logic          ld_ready;
  logic          cpu_rst;
  logic          ld_ovf;

  modport master (
    output pmar, dmr, dmar, dmw, dmaw, dmdw, ld_valid, ld_data, ld_last,
    input  pmdr, dmdr, ld_ready, cpu_rst, ld_ovf
  );

  modport slave (
    input  pmar, dmr, dmar, dmw, dmaw, dmdw, ld_valid, ld_data, ld_last,
    output pmdr, dmdr, ld_ready, cpu_rst, ld_ovf
  );

endinterface

// File: rtl/riscv_mem_responder_loader.sv
// Boot-load FSM: accepts a byte stream into consecutive addresses from 0
// while holding the core in reset, then switches to RUN until the next reset.
module riscv_mem_loader
  import riscv_mem_pkg::*;
#(
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          r,
  input  logic          ld_valid,
  input  logic [7:0]    ld_data,
  input  logic          ld_last,
  output logic          ld_ready,
  output logic          cpu_rst,
  output logic          ld_ovf,
  output logic          run,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data
);

  state_e        state_r;
  state_e        state_nxt_s;
  logic [AW-1:0] ld_ptr_r;
  logic          ld_ready_r;
  logic          cpu_rst_r;
  logic          ld_ovf_r;
  logic          hs_s;

  assign hs_s = ld_valid & ld_ready_r & (state_r == ST_LOAD);

  // Next-state: leave LOAD only after the handshake carrying the last byte.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_LOAD: begin
        if (hs_s && ld_last) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_LOAD;
        end
      end
      ST_RUN:  state_nxt_s = ST_RUN;
      default: state_nxt_s = ST_LOAD;
    endcase
  end

  // State, pointer and registered handshake/status outputs.
  always_ff @(posedge clk) begin
    if (r) begin
      state_r    <= ST_LOAD;
      ld_ptr_r   <= {AW{1'b0}};
      ld_ready_r <= 1'b0;
      cpu_rst_r  <= 1'b1;
      ld_ovf_r   <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      ld_ready_r <= (state_nxt_s == ST_LOAD);
      cpu_rst_r  <= (state_nxt_s == ST_LOAD);
      if (hs_s) begin
        ld_ptr_r <= ld_ptr_r + {{(AW-1){1'b0}}, 1'b1};
        if (ld_ptr_r == {AW{1'b1}}) begin
          ld_ovf_r <= 1'b1;
        end
      end
    end
  end

  assign ld_ready = ld_ready_r;
  assign cpu_rst  = cpu_rst_r;
  assign ld_ovf   = ld_ovf_r;
  assign run      = (state_r == ST_RUN);
  // A reset cycle takes priority over a concurrent handshake.
  assign wr_en    = hs_s & ~r;
  assign wr_addr  = ld_ptr_r;
  assign wr_data  = ld_data;

endmodule

// File: rtl/riscv_mem_responder.sv
// Memory-side responder for the core's PM and DM buses: a unified
// little-endian byte store with registered word reads and sized DM writes,
// filled at boot by riscv_mem_loader.
// Build option: define MEM_WR_FWD_EN to forward same-cycle DM write bytes
// into the PM/DM read data (write-first); otherwise reads see pre-write data.
module riscv_mem_responder
  import riscv_mem_pkg::*;
#(
  parameter int          AW       = 16,
  parameter logic [31:0] NOP_INSN = riscv_mem_pkg::NOP_INSN
) (
  input  logic                  clk,
  input  logic                  r,
  riscv_mem_responder_if.slave  bus
);

  localparam int DEPTH = 2 ** AW;

  logic [7:0]    mem_r [0:DEPTH-1];
  logic [31:0]   pmdr_r;
  logic [31:0]   dmdr_r;

  logic          run_s;
  logic          ld_we_s;
  logic [AW-1:0] ld_addr_s;
  logic [7:0]    ld_byte_s;

  logic [AW-1:0] pm_addr_s [4];
  logic [AW-1:0] dm_addr_s [4];
  logic [AW-1:0] wr_addr_s [4];
  logic [7:0]    wr_byte_s [4];
  logic [3:0]    dm_mask_s;
  logic [31:0]   pm_rd_s;
  logic [31:0]   dm_rd_s;

  riscv_mem_loader #(.AW(AW)) u_loader (
    .clk      (clk),
    .r        (r),
    .ld_valid (bus.ld_valid),
    .ld_data  (bus.ld_data),
    .ld_last  (bus.ld_last),
    .ld_ready (bus.ld_ready),
    .cpu_rst  (bus.cpu_rst),
    .ld_ovf   (bus.ld_ovf),
    .run      (run_s),
    .wr_en    (ld_we_s),
    .wr_addr  (ld_addr_s),
    .wr_data  (ld_byte_s)
  );

  // DM writes only land in RUN and never in a reset cycle.
  assign dm_mask_s = (run_s && !r) ? size_mask(bus.dmw) : 4'b0000;

  // Per-byte addresses wrap modulo the store size; write bytes by lane.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      pm_addr_s[k] = bus.pmar + AW'(k);
      dm_addr_s[k] = bus.dmar + AW'(k);
      wr_addr_s[k] = bus.dmaw + AW'(k);
      wr_byte_s[k] = bus.dmdw[8*k +: 8];
    end
  end

  // Assemble little-endian read words, optionally overlaying same-cycle writes.
  always_comb begin
    pm_rd_s = 32'h00000000;
    dm_rd_s = 32'h00000000;
    for (int k = 0; k < 4; k++) begin
      pm_rd_s[8*k +: 8] = mem_r[pm_addr_s[k]];
      dm_rd_s[8*k +: 8] = mem_r[dm_addr_s[k]];
`ifdef MEM_WR_FWD_EN
      for (int j = 0; j < 4; j++) begin
        pm_rd_s[8*k +: 8] = (dm_mask_s[j] && (wr_addr_s[j] == pm_addr_s[k]))
                            ? wr_byte_s[j] : pm_rd_s[8*k +: 8];
        dm_rd_s[8*k +: 8] = (dm_mask_s[j] && (wr_addr_s[j] == dm_addr_s[k]))
                            ? wr_byte_s[j] : dm_rd_s[8*k +: 8];
      end
`else
      pm_rd_s[8*k +: 8] = pm_rd_s[8*k +: 8];
`endif
    end
  end

  // Registered read ports: NOP/zero while loading, live data in RUN.
  always_ff @(posedge clk) begin
    if (r) begin
      pmdr_r <= 32'h00000000;
      dmdr_r <= 32'h00000000;
    end else if (!run_s) begin
      pmdr_r <= NOP_INSN;
      dmdr_r <= 32'h00000000;
    end else begin
      pmdr_r <= pm_rd_s;
      if (bus.dmr) begin
        dmdr_r <= dm_rd_s;
      end else begin
        dmdr_r <= dmdr_r;
      end
    end
  end

  // Byte store: loader writes in LOAD, sized DM writes in RUN; never cleared.
  always_ff @(posedge clk) begin
    if (ld_we_s) begin
      mem_r[ld_addr_s] <= ld_byte_s;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (dm_mask_s[k]) begin
          mem_r[wr_addr_s[k]] <= wr_byte_s[k];
        end
      end
    end
  end

  assign bus.pmdr = pmdr_r;
  assign bus.dmdr = dmdr_r;

endmodule
